// File: rtl/fifo_relay_pkg.sv
//------------------------------------------------------------------------------
// fifo_relay_pkg - shared state encoding and grace-period helper for fifo relays
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_relay_pkg;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2
   } relay_state_t;

   // Smallest downstream slack that absorbs a full write/full_n round trip.
   function automatic int min_grace(input int level);
      return 2 * level;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_relay_if.sv
//------------------------------------------------------------------------------
// fifo_write_relay_if - upstream FWFT read port plus downstream write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_write_relay_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  in_empty_n;
   logic                  in_read;
   logic [DATA_WIDTH-1:0] in_dout;
   logic                  out_write;
   logic [DATA_WIDTH-1:0] out_din;
   logic                  out_full_n;

   modport master (
      input  in_empty_n,
      input  in_dout,
      input  out_full_n,
      output in_read,
      output out_write,
      output out_din
   );

   modport slave (
      output in_empty_n,
      output in_dout,
      output out_full_n,
      input  in_read,
      input  out_write,
      input  out_din
   );

endinterface

`default_nettype wire

// File: rtl/relay_shift_reg.sv
//------------------------------------------------------------------------------
// relay_shift_reg - synchronous-reset register chain, all taps exposed
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module relay_shift_reg #(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [WIDTH-1:0]               d,
   output logic [STAGES-1:0][WIDTH-1:0]   q
);

   logic [STAGES-1:0][WIDTH-1:0] r_pipe;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            r_pipe[k] <= RESET_VAL;
         end
      end else begin
         r_pipe[0] <= d;
         for (int k = 1; k < STAGES; k++) begin
            r_pipe[k] <= r_pipe[k-1];
         end
      end
   end

   assign q = r_pipe;

endmodule

`default_nettype wire

// File: rtl/fifo_write_relay.sv
//------------------------------------------------------------------------------
// fifo_write_relay - drains an FWFT FIFO into a distant almost-full FIFO write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_write_relay
   import fifo_relay_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int LEVEL        = 2,
   parameter int GRACE_PERIOD = 4,
   parameter int CNT_WIDTH    = 8
) (
   input  logic               clk,
   input  logic               reset,
   fifo_write_relay_if.master bus,
   output logic               overflow_err,
   output logic               busy
);

   localparam int                   c_FLUSH_W    = (LEVEL > 1) ? $clog2(LEVEL) : 1;
   localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(LEVEL - 1);
   localparam logic [CNT_WIDTH-1:0] c_GRACE      = CNT_WIDTH'(GRACE_PERIOD);
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX    = '1;

   if (LEVEL < 1 || GRACE_PERIOD < min_grace(LEVEL) ||
       GRACE_PERIOD + 1 > (2 ** CNT_WIDTH) - 1) begin : g_param_check
      $error("fifo_write_relay: illegal LEVEL/GRACE_PERIOD/CNT_WIDTH combination");
   end

   relay_state_t                    r_state;
   relay_state_t                    w_state_nxt;
   logic [c_FLUSH_W-1:0]            r_flush_cnt;
   logic                            w_in_read;
   logic                            w_fn;
   logic                            w_out_write;
   logic [DATA_WIDTH-1:0]           w_data_d;
   logic [LEVEL-1:0][0:0]           w_valid_q;
   logic [LEVEL-1:0][DATA_WIDTH-1:0] w_data_q;
   logic [LEVEL-1:0][0:0]           w_full_q;
   logic [CNT_WIDTH-1:0]            r_credit;
   logic                            r_overflow;
   logic                            w_unused_taps;

   // Backward path: full_n resets to 0 so nothing is read until real samples arrive.
   relay_shift_reg #(.WIDTH(1), .STAGES(LEVEL), .RESET_VAL(1'b0)) u_full_pipe (
      .clk   (clk),
      .reset (reset),
      .d     (bus.out_full_n),
      .q     (w_full_q)
   );

   relay_shift_reg #(.WIDTH(1), .STAGES(LEVEL), .RESET_VAL(1'b0)) u_valid_pipe (
      .clk   (clk),
      .reset (reset),
      .d     (w_in_read),
      .q     (w_valid_q)
   );

   relay_shift_reg #(.WIDTH(DATA_WIDTH), .STAGES(LEVEL), .RESET_VAL('0)) u_data_pipe (
      .clk   (clk),
      .reset (reset),
      .d     (w_data_d),
      .q     (w_data_q)
   );

   assign w_fn          = w_full_q[LEVEL-1][0];
   assign w_data_d      = w_in_read ? bus.in_dout : w_data_q[0];
   assign w_out_write   = w_valid_q[LEVEL-1][0];
   assign w_unused_taps = ^{w_full_q, w_data_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= FLUSH;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == FLUSH) begin
            r_flush_cnt <= r_flush_cnt + c_FLUSH_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_read   = 1'b0;
      case (r_state)
         FLUSH: begin
            if (r_flush_cnt == c_FLUSH_LAST) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_in_read = bus.in_empty_n & w_fn;
            if (!w_fn) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_fn) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = FLUSH;
      endcase
   end

   // Counts writes landing while the far end reports full; more than the slack is a bug.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_credit   <= '0;
         r_overflow <= 1'b0;
      end else if (bus.out_full_n) begin
         r_credit <= '0;
      end else if (w_out_write) begin
         if (r_credit != c_CNT_MAX) begin
            r_credit <= r_credit + CNT_WIDTH'(1);
         end
         if (r_credit == c_GRACE) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign bus.in_read   = w_in_read;
   assign bus.out_write = w_out_write;
   assign bus.out_din   = w_data_q[LEVEL-1];
   assign overflow_err  = r_overflow;
   assign busy          = |w_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_relay.sv
//------------------------------------------------------------------------------
// tb_fifo_write_relay - directed vectors and corner sequences for fifo_write_relay
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_write_relay;
   import fifo_relay_pkg::*;

   localparam int DW      = 32;
   localparam int LEVEL_A = 2;
   localparam int GRACE_A = min_grace(LEVEL_A);
   localparam int LEVEL_B = 1;
   localparam int GRACE_B = min_grace(LEVEL_B);

   logic          clk = 1'b0;
   logic          reset;
   logic          empty_n;
   logic          full_n;
   logic [DW-1:0] dout;
   logic          sel_b;
   logic          overflow_a, busy_a, overflow_b, busy_b;
   logic          m_read, m_write, m_busy, m_ovf;
   logic [DW-1:0] m_din;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            cyc    = 0;
   logic [DW-1:0] din_v;
   logic [DW-1:0] sb[$];

   fifo_write_relay_if #(.DATA_WIDTH(DW)) ifa ();
   fifo_write_relay_if #(.DATA_WIDTH(DW)) ifb ();

   fifo_write_relay #(.DATA_WIDTH(DW), .LEVEL(LEVEL_A), .GRACE_PERIOD(GRACE_A), .CNT_WIDTH(8)) dut_a (
      .clk          (clk),
      .reset        (reset),
      .bus          (ifa),
      .overflow_err (overflow_a),
      .busy         (busy_a)
   );

   fifo_write_relay #(.DATA_WIDTH(DW), .LEVEL(LEVEL_B), .GRACE_PERIOD(GRACE_B), .CNT_WIDTH(8)) dut_b (
      .clk          (clk),
      .reset        (reset),
      .bus          (ifb),
      .overflow_err (overflow_b),
      .busy         (busy_b)
   );

   always #5 clk = ~clk;

   assign ifa.in_empty_n = empty_n;
   assign ifa.in_dout    = dout;
   assign ifa.out_full_n = full_n;
   assign ifb.in_empty_n = empty_n;
   assign ifb.in_dout    = dout;
   assign ifb.out_full_n = full_n;

   assign m_read  = sel_b ? ifb.in_read   : ifa.in_read;
   assign m_write = sel_b ? ifb.out_write : ifa.out_write;
   assign m_din   = sel_b ? ifb.out_din   : ifa.out_din;
   assign m_busy  = sel_b ? busy_b        : busy_a;
   assign m_ovf   = sel_b ? overflow_b    : overflow_a;

   typedef struct packed {
      logic          empty_n;
      logic          full_n;
      logic [DW-1:0] dout;
      logic          exp_read;
      logic          exp_write;
      logic [DW-1:0] exp_din;
      logic          exp_busy;
   } vec_t;

   vec_t tv[20];

   function automatic vec_t mk(input logic en, input logic fn, input logic [DW-1:0] d,
                               input logic rd, input logic wr, input logic [DW-1:0] od,
                               input logic bz);
      vec_t v;
      v.empty_n   = en;
      v.full_n    = fn;
      v.dout      = d;
      v.exp_read  = rd;
      v.exp_write = wr;
      v.exp_din   = od;
      v.exp_busy  = bz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   // Samples the pop decision just before the edge, then models the FWFT pop.
   task automatic tick();
      logic rd;
      rd = m_read;
      @(posedge clk);
      #1;
      cyc++;
      if (rd) begin
         sb.push_back(dout);
         din_v = din_v + 1;
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      empty_n = 1'b0;
      full_n  = 1'b1;
      dout    = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      sb.delete();
   endtask

   task automatic check_write_data(input string name);
      if (m_write) begin
         if (sb.size() == 0) begin
            chk({name, "_unexpected"}, 32'd1, 32'd0);
         end else begin
            chk(name, m_din, sb.pop_front());
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_stall_wr;
      int n_prev;
      logic exp_rd, exp_wr;

      // 8-word burst (A) then 1,0,1,0 upstream pattern (B); LEVEL=2 latency.
      tv[0]  = mk(1, 1, 32'hA000_0000, 0, 0, 32'h0,          0);
      tv[1]  = mk(1, 1, 32'hA000_0000, 0, 0, 32'h0,          0);
      tv[2]  = mk(1, 1, 32'hA000_0000, 1, 0, 32'h0,          0);
      tv[3]  = mk(1, 1, 32'hA000_0001, 1, 0, 32'h0,          1);
      tv[4]  = mk(1, 1, 32'hA000_0002, 1, 1, 32'hA000_0000, 1);
      tv[5]  = mk(1, 1, 32'hA000_0003, 1, 1, 32'hA000_0001, 1);
      tv[6]  = mk(1, 1, 32'hA000_0004, 1, 1, 32'hA000_0002, 1);
      tv[7]  = mk(1, 1, 32'hA000_0005, 1, 1, 32'hA000_0003, 1);
      tv[8]  = mk(1, 1, 32'hA000_0006, 1, 1, 32'hA000_0004, 1);
      tv[9]  = mk(1, 1, 32'hA000_0007, 1, 1, 32'hA000_0005, 1);
      tv[10] = mk(0, 1, 32'hA000_0007, 0, 1, 32'hA000_0006, 1);
      tv[11] = mk(0, 1, 32'hA000_0007, 0, 1, 32'hA000_0007, 1);
      tv[12] = mk(0, 1, 32'hA000_0007, 0, 0, 32'h0,          0);
      tv[13] = mk(0, 1, 32'hA000_0007, 0, 0, 32'h0,          0);
      tv[14] = mk(1, 1, 32'hB000_0000, 1, 0, 32'h0,          0);
      tv[15] = mk(0, 1, 32'hB000_0001, 0, 0, 32'h0,          1);
      tv[16] = mk(1, 1, 32'hB000_0001, 1, 1, 32'hB000_0000, 1);
      tv[17] = mk(0, 1, 32'hB000_0002, 0, 0, 32'h0,          1);
      tv[18] = mk(0, 1, 32'hB000_0002, 0, 1, 32'hB000_0001, 1);
      tv[19] = mk(0, 1, 32'hB000_0002, 0, 0, 32'h0,          0);

      sel_b = 1'b0;
      din_v = '0;
      do_reset();
      chk("reset_state", dut_a.r_state, FLUSH);
      chk("reset_ovf", m_ovf, 1'b0);

      for (int i = 0; i < 20; i++) begin
         empty_n = tv[i].empty_n;
         full_n  = tv[i].full_n;
         dout    = tv[i].dout;
         #1;
         chk("vec_read", m_read, tv[i].exp_read);
         chk("vec_write", m_write, tv[i].exp_write);
         if (tv[i].exp_write) chk("vec_din", m_din, tv[i].exp_din);
         chk("vec_busy", m_busy, tv[i].exp_busy);
         chk("vec_ovf", m_ovf, 1'b0);
         tick();
      end

      // Stall: full_n low for cycles 20..29; fn low 22..31, plus HOLD exit bubble at 32.
      do_reset();
      din_v      = 32'hC000_0000;
      n_stall_wr = 0;
      for (int c = 0; c < 42; c++) begin
         empty_n = 1'b1;
         full_n  = !(c >= 20 && c < 30);
         dout    = din_v;
         #1;
         exp_rd = (c >= 2 && c <= 21) || (c >= 33);
         exp_wr = (c >= 4 && c <= 23) || (c >= 35);
         chk("stall_read", m_read, exp_rd);
         chk("stall_write", m_write, exp_wr);
         if (m_write && !full_n) n_stall_wr++;
         check_write_data("stall_din");
         tick();
      end
      chk("stall_writes_while_full", n_stall_wr, 2 * LEVEL_A);
      chk("stall_ovf", m_ovf, 1'b0);

      // Illegal run: fn held high while far end is full; 5th write sets overflow.
      full_n = 1'b0;
      force dut_a.w_fn = 1'b1;
      n_prev = 0;
      for (int k = 0; k < 10; k++) begin
         empty_n = 1'b1;
         dout    = din_v;
         #1;
         chk("force_write", m_write, 1'b1);
         chk("force_ovf", m_ovf, n_prev >= GRACE_A + 1);
         if (m_write) n_prev++;
         check_write_data("force_din");
         tick();
      end
      release dut_a.w_fn;
      full_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         empty_n = 1'b1;
         dout    = din_v;
         #1;
         chk("sticky_ovf", m_ovf, 1'b1);
         check_write_data("resume_din");
         tick();
      end
      chk("busy_before_reset", m_busy, 1'b1);

      // Reset with words in flight: they must vanish.
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      sb.delete();
      chk("midrst_write", m_write, 1'b0);
      chk("midrst_busy", m_busy, 1'b0);
      chk("midrst_state", dut_a.r_state, FLUSH);
      chk("midrst_ovf", m_ovf, 1'b0);
      for (int c = 0; c < 7; c++) begin
         empty_n = 1'b1;
         full_n  = 1'b1;
         dout    = din_v;
         #1;
         chk("postrst_read", m_read, c >= 2);
         chk("postrst_write", m_write, c >= 4);
         check_write_data("postrst_din");
         tick();
      end

      // LEVEL=1: one-cycle latency; single full_n dip gives fn gap at 11 plus HOLD bubble at 12.
      sel_b = 1'b1;
      do_reset();
      din_v = 32'hD000_0000;
      for (int c = 0; c < 20; c++) begin
         empty_n = 1'b1;
         full_n  = (c != 10);
         dout    = din_v;
         #1;
         exp_rd = (c >= 1) && !(c == 11 || c == 12);
         exp_wr = (c >= 2) && !(c == 12 || c == 13);
         chk("l1_read", m_read, exp_rd);
         chk("l1_write", m_write, exp_wr);
         chk("l1_ovf", m_ovf, 1'b0);
         check_write_data("l1_din");
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
